// File: rtl/csr_issue_queue.sv
// csr_issue_queue: in-order CSR buffer issuing each op only once it is the oldest uncommitted ROB entry
module csr_issue_queue #(
   parameter int DEPTH              = 4,
   parameter int ROB_INDEX_WIDTH    = 4,
   parameter int PHY_REG_ADDR_WIDTH = 6,
   parameter int XLEN               = 64,
   parameter int IMM_LEN            = 5,
   parameter int CSR_ADDR_LEN       = 12
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rcu_csrq_vld_i,
   output logic                          csrq_rcu_rdy_o,
   input  logic [ROB_INDEX_WIDTH-1:0]    rcu_rob_index_i,
   input  logic [PHY_REG_ADDR_WIDTH-1:0] rcu_prd_addr_i,
   input  logic [2:0]                    rcu_func3_i,
   input  logic [XLEN-1:0]               rcu_prs1_data_i,
   input  logic [IMM_LEN-1:0]            rcu_imm_i,
   input  logic [CSR_ADDR_LEN-1:0]       rcu_csr_addr_i,
   input  logic                          rcu_csr_do_read_i,
   input  logic                          rcu_csr_do_write_i,
   input  logic [ROB_INDEX_WIDTH-1:0]    rob_head_index_i,
   input  logic                          flush_i,
   output logic                          csr_req_valid_o,
   output logic [ROB_INDEX_WIDTH-1:0]    csr_rob_index_o,
   output logic [PHY_REG_ADDR_WIDTH-1:0] csr_prd_addr_o,
   output logic [2:0]                    csr_func3_o,
   output logic [XLEN-1:0]               csr_prs1_data_o,
   output logic [IMM_LEN-1:0]            csr_imm_o,
   output logic [CSR_ADDR_LEN-1:0]       csr_addr_o,
   output logic                          csr_do_read_o,
   output logic                          csr_do_write_o,
   output logic                          csrq_empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int W  = ROB_INDEX_WIDTH + PHY_REG_ADDR_WIDTH + 3 + XLEN + IMM_LEN + CSR_ADDR_LEN + 2;
   localparam logic [1:0] IDLE        = 2'd0;
   localparam logic [1:0] WAIT_HEAD   = 2'd1;
   localparam logic [1:0] ISSUE       = 2'd2;
   localparam logic [1:0] WAIT_RETIRE = 2'd3;

   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  din, out_q;
   logic [AW-1:0] head, tail;
   logic [AW:0]   count;
   logic [1:0]    state, state_nxt;
   logic          push, pop;

   assign din = {rcu_rob_index_i, rcu_prd_addr_i, rcu_func3_i, rcu_prs1_data_i,
                 rcu_imm_i, rcu_csr_addr_i, rcu_csr_do_read_i, rcu_csr_do_write_i};
   assign {csr_rob_index_o, csr_prd_addr_o, csr_func3_o, csr_prs1_data_o,
           csr_imm_o, csr_addr_o, csr_do_read_o, csr_do_write_o} = out_q;

   // DEPTH is a power of two, so the count MSB alone flags full
   assign csrq_rcu_rdy_o  = ~count[AW];
   assign push            = rcu_csrq_vld_i & csrq_rcu_rdy_o & ~flush_i;
   assign pop             = (state == WAIT_HEAD) & (count != 0) & ~flush_i &
                            (mem[head][W-1 -: ROB_INDEX_WIDTH] == rob_head_index_i);
   assign csr_req_valid_o = (state == ISSUE);
   assign csrq_empty_o    = (count == 0) & (state == IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        state_nxt = push ? WAIT_HEAD : IDLE;
         WAIT_HEAD:   state_nxt = pop ? ISSUE : WAIT_HEAD;
         ISSUE:       state_nxt = WAIT_RETIRE;
         default:     state_nxt = (rob_head_index_i == csr_rob_index_o) ? WAIT_RETIRE :
                                  ((count != 0) | push) ? WAIT_HEAD : IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (push) mem[tail] <= din;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= IDLE;
         out_q <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= IDLE;
      end else begin
         state <= state_nxt;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (push) tail <= tail + 1'b1;
         if (pop) begin
            head  <= head + 1'b1;
            out_q <= mem[head];
         end
      end
   end
endmodule

// File: tb/tb_csr_issue_queue.sv
// tb_csr_issue_queue: scoreboard bench for csr_issue_queue (issue order, gating, flush, wrap, reset)
module tb_csr_issue_queue;
   typedef struct packed {
      logic [3:0]  rob;
      logic [5:0]  prd;
      logic [2:0]  f3;
      logic [63:0] rs1;
      logic [4:0]  imm;
      logic [11:0] addr;
      logic        rd;
      logic        wr;
   } pl_t;

   logic        clk = 0, rst = 0, rcu_csrq_vld_i = 0, flush_i = 0;
   logic        csrq_rcu_rdy_o, csr_req_valid_o, csrq_empty_o;
   logic [3:0]  rcu_rob_index_i = 0, rob_head_index_i = 0, csr_rob_index_o;
   logic [5:0]  rcu_prd_addr_i = 0, csr_prd_addr_o;
   logic [2:0]  rcu_func3_i = 0, csr_func3_o;
   logic [63:0] rcu_prs1_data_i = 0, csr_prs1_data_o;
   logic [4:0]  rcu_imm_i = 0, csr_imm_o;
   logic [11:0] rcu_csr_addr_i = 0, csr_addr_o;
   logic        rcu_csr_do_read_i = 0, rcu_csr_do_write_i = 0, csr_do_read_o, csr_do_write_o;

   int   checks = 0, failures = 0, cyc = 0, last_iss = -1;
   pl_t  sb[$];
   pl_t  obs, p;

   csr_issue_queue dut (
      .clk(clk), .rst(rst),
      .rcu_csrq_vld_i(rcu_csrq_vld_i), .csrq_rcu_rdy_o(csrq_rcu_rdy_o),
      .rcu_rob_index_i(rcu_rob_index_i), .rcu_prd_addr_i(rcu_prd_addr_i),
      .rcu_func3_i(rcu_func3_i), .rcu_prs1_data_i(rcu_prs1_data_i),
      .rcu_imm_i(rcu_imm_i), .rcu_csr_addr_i(rcu_csr_addr_i),
      .rcu_csr_do_read_i(rcu_csr_do_read_i), .rcu_csr_do_write_i(rcu_csr_do_write_i),
      .rob_head_index_i(rob_head_index_i), .flush_i(flush_i),
      .csr_req_valid_o(csr_req_valid_o), .csr_rob_index_o(csr_rob_index_o),
      .csr_prd_addr_o(csr_prd_addr_o), .csr_func3_o(csr_func3_o),
      .csr_prs1_data_o(csr_prs1_data_o), .csr_imm_o(csr_imm_o),
      .csr_addr_o(csr_addr_o), .csr_do_read_o(csr_do_read_o),
      .csr_do_write_o(csr_do_write_o), .csrq_empty_o(csrq_empty_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (rst && csr_req_valid_o) begin
         obs = {csr_rob_index_o, csr_prd_addr_o, csr_func3_o, csr_prs1_data_o,
                csr_imm_o, csr_addr_o, csr_do_read_o, csr_do_write_o};
         if (sb.size() == 0) chk("unexp_issue", csr_req_valid_o, 0);
         else chk("issue_payload", obs, sb.pop_front());
         if (last_iss >= 0) chk("issue_spacing", 128'(cyc - last_iss >= 3), 1);
         last_iss = cyc;
      end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic pl_t mk(input int idx);
      pl_t r;
      r.rob  = 4'(idx);
      r.prd  = 6'($urandom);
      r.f3   = 3'($urandom);
      r.rs1  = {$urandom, $urandom};
      r.imm  = 5'($urandom);
      r.addr = 12'($urandom);
      r.rd   = 1'($urandom);
      r.wr   = 1'($urandom);
      return r;
   endfunction

   task automatic enq(input pl_t q, input bit acc);
      rcu_csrq_vld_i = 1;
      {rcu_rob_index_i, rcu_prd_addr_i, rcu_func3_i, rcu_prs1_data_i,
       rcu_imm_i, rcu_csr_addr_i, rcu_csr_do_read_i, rcu_csr_do_write_i} = q;
      @(negedge clk);
      chk("rdy", csrq_rcu_rdy_o, acc);
      if (acc) sb.push_back(q);
      tick;
      rcu_csrq_vld_i = 0;
   endtask

   task automatic wait_issue(input string tag);
      bit f = 0;
      for (int k = 0; k < 20 && !f; k++) begin
         @(negedge clk);
         f = csr_req_valid_o;
         tick;
      end
      chk(tag, f, 1);
   endtask

   initial begin
      #1;
      chk("rst_rdy", csrq_rcu_rdy_o, 1);
      chk("rst_empty", csrq_empty_o, 1);
      chk("rst_valid", csr_req_valid_o, 0);
      tick; tick;
      rst = 1;
      tick;
      // single op, head already matching: request two cycles after enqueue
      rob_head_index_i = 3;
      p = mk(3); p.addr = 12'h300; p.f3 = 3'b001; p.rs1 = 64'h8;
      enq(p, 1);
      @(negedge clk); chk("t1_n1", csr_req_valid_o, 0);
      tick;
      @(negedge clk); chk("t1_n2", csr_req_valid_o, 1); chk("t1_addr", csr_addr_o, 12'h300);
      tick;
      @(negedge clk); chk("t1_n3", csr_req_valid_o, 0);
      rob_head_index_i = 4;
      tick;
      @(negedge clk); chk("t1_empty", csrq_empty_o, 1);
      tick;
      // head gating
      rob_head_index_i = 2;
      enq(mk(5), 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); chk("t2_hold", csr_req_valid_o, 0);
         tick;
      end
      rob_head_index_i = 5;
      @(negedge clk); chk("t2_match", csr_req_valid_o, 0);
      tick;
      @(negedge clk); chk("t2_issue", csr_req_valid_o, 1);
      tick;
      rob_head_index_i = 6;
      tick; tick;
      // full and back-pressure
      rob_head_index_i = 15;
      for (int i = 0; i < 4; i++) enq(mk(i), 1);
      enq(mk(4), 0);
      for (int i = 0; i < 4; i++) begin
         rob_head_index_i = 4'(i);
         wait_issue("t3_issue");
         if (i == 0) begin
            @(negedge clk); chk("t3_rdy_back", csrq_rcu_rdy_o, 1);
            tick;
         end
      end
      rob_head_index_i = 4;
      tick; tick;
      // double-issue guard
      rob_head_index_i = 7;
      enq(mk(7), 1);
      enq(mk(8), 1);
      wait_issue("t4_issue7");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); chk("t4_stall", csr_req_valid_o, 0);
         tick;
      end
      rob_head_index_i = 8;
      wait_issue("t4_issue8");
      rob_head_index_i = 9;
      tick; tick;
      // flush with a same-cycle enqueue
      rob_head_index_i = 0;
      enq(mk(9), 1);
      enq(mk(10), 1);
      enq(mk(11), 1);
      p = mk(12);
      {rcu_rob_index_i, rcu_prd_addr_i, rcu_func3_i, rcu_prs1_data_i,
       rcu_imm_i, rcu_csr_addr_i, rcu_csr_do_read_i, rcu_csr_do_write_i} = p;
      rcu_csrq_vld_i = 1;
      flush_i = 1;
      tick;
      rcu_csrq_vld_i = 0;
      flush_i = 0;
      sb.delete();
      @(negedge clk); chk("t5_empty", csrq_empty_o, 1); chk("t5_rdy", csrq_rcu_rdy_o, 1);
      tick;
      for (int i = 9; i < 13; i++) begin
         rob_head_index_i = 4'(i);
         tick; tick; tick;
      end
      @(negedge clk); chk("t5_no_issue", csr_req_valid_o, 0);
      tick;
      // pointer wrap with sequential ops
      for (int i = 0; i < 10; i++) begin
         rob_head_index_i = 4'(i);
         enq(mk(i), 1);
         wait_issue("t6_issue");
      end
      rob_head_index_i = 15;
      tick; tick;
      // asynchronous reset mid-queue
      enq(mk(0), 1);
      enq(mk(1), 1);
      enq(mk(2), 1);
      #2 rst = 0;
      #1;
      chk("ar_valid", csr_req_valid_o, 0);
      chk("ar_rdy", csrq_rcu_rdy_o, 1);
      chk("ar_empty", csrq_empty_o, 1);
      chk("ar_rob", csr_rob_index_o, 0);
      chk("ar_data", csr_prs1_data_o, 0);
      sb.delete();
      tick;
      rst = 1;
      tick;
      rob_head_index_i = 5;
      enq(mk(5), 1);
      wait_issue("ar_after");
      chk("sb_drained", 128'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
